// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transceiver.
// Build option: UART_RX_SYNC_EN selects a 2-flop rx synchronizer (default: single input register).
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int MIN_BIT_PERIOD = 4;

`ifdef UART_RX_SYNC_EN
    localparam int RX_SYNC_STAGES = 2;
`else
    localparam int RX_SYNC_STAGES = 1;
`endif

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchronizer, falling-edge detect, mid-bit sampling FSM, data register.
// Build option: UART_RX_SYNC_EN selects 2 synchronizer flops instead of 1.
// Receive FSM state is held in state_q for observation.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CFG_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [CFG_W-1:0] bit_period,
    input  logic             rx,
    output logic             rx_valid,
    output logic [7:0]       rx_data
);

    localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

    logic [RX_SYNC_STAGES-1:0] sync_q;
    logic                      rx_s;
    logic                      rx_prev;
    logic                      fall;

    rx_state_t                 state_q, state_n;
    logic [CFG_W-1:0]          cnt_q, cnt_n;
    logic [CFG_W-1:0]          period_q, period_n;
    logic [2:0]                idx_q, idx_n;
    logic [DATA_BITS-1:0]      sh_q, sh_n;
    logic                      valid_n;
    logic [7:0]                data_n;
    logic [CFG_W-1:0]          last_cnt;
    logic [CFG_W-1:0]          half_cnt;

    // Bring rx into the clock domain; flops reset to the idle (high) line level.
`ifdef UART_RX_SYNC_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sync_q <= '1;
        else       sync_q <= {sync_q[0], rx};
    end
`else
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sync_q <= '1;
        else       sync_q <= rx;
    end
`endif

    assign rx_s = sync_q[RX_SYNC_STAGES-1];

    // Previous synchronized sample, so only a 1->0 transition starts a frame.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) rx_prev <= 1'b1;
        else       rx_prev <= rx_s;
    end

    assign fall     = rx_prev & ~rx_s;
    assign last_cnt = period_q - ONE;
    assign half_cnt = (period_q >> 1) - ONE;

    // Receive FSM and datapath registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            period_q <= period_n;
            idx_q    <= idx_n;
            sh_q     <= sh_n;
            rx_valid <= valid_n;
            rx_data  <= data_n;
        end
    end

    // Next-state: start-bit check at half period, then one sample per bit period.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q + ONE;
        period_n = period_q;
        idx_n    = idx_q;
        sh_n     = sh_q;
        valid_n  = 1'b0;
        data_n   = rx_data;
        case (state_q)
            RX_IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    state_n  = RX_START;
                    period_n = bit_period;
                end
            end
            RX_START: begin
                if (cnt_q == half_cnt) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // A high line at mid start bit means the edge was a glitch.
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == last_cnt) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh_q[DATA_BITS-1:1]};
                    if (idx_q == 3'd7) state_n = RX_STOP;
                    else               idx_n   = idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == last_cnt) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    // A low stop bit is a framing error: the byte is dropped.
                    if (rx_s) begin
                        valid_n = 1'b1;
                        data_n  = sh_q;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx receiver, runtime bit period.
// Build option: UART_RX_SYNC_EN (passed to uart_rx) adds a second rx synchronizer flop.
// Transmit FSM state is held in tx_state_q for observation.
module uart
    import uart_pkg::*;
#(
    parameter int CFG_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [CFG_W-1:0] baudrate_cfg,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             tx_busy,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             tx,
    input  logic             rx
);

    localparam logic [CFG_W-1:0] ONE   = CFG_W'(1);
    localparam logic [CFG_W-1:0] MIN_B = CFG_W'(MIN_BIT_PERIOD);

    logic [CFG_W-1:0]     bit_period;

    tx_state_t            tx_state_q, tx_state_n;
    logic [CFG_W-1:0]     tx_cnt_q, tx_cnt_n;
    logic [CFG_W-1:0]     tx_period_q, tx_period_n;
    logic [2:0]           tx_idx_q, tx_idx_n;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_n;
    logic                 tx_n;
    logic                 tx_busy_n;
    logic [CFG_W-1:0]     tx_last;

    // Periods shorter than the minimum are raised to it.
    assign bit_period = (baudrate_cfg < MIN_B) ? MIN_B : baudrate_cfg;
    assign tx_last    = tx_period_q - ONE;

    // Transmit FSM and registered serial outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_period_q <= '0;
            tx_idx_q    <= '0;
            tx_sh_q     <= '0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_n;
            tx_cnt_q    <= tx_cnt_n;
            tx_period_q <= tx_period_n;
            tx_idx_q    <= tx_idx_n;
            tx_sh_q     <= tx_sh_n;
            tx          <= tx_n;
            tx_busy     <= tx_busy_n;
        end
    end

    // Next-state: each bit is held for one latched bit period; data shifts out LSB first.
    always_comb begin
        tx_state_n  = tx_state_q;
        tx_cnt_n    = tx_cnt_q + ONE;
        tx_period_n = tx_period_q;
        tx_idx_n    = tx_idx_q;
        tx_sh_n     = tx_sh_q;
        tx_n        = tx;
        tx_busy_n   = tx_busy;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (wr_en && !tx_busy) begin
                    tx_state_n  = TX_START;
                    tx_sh_n     = wr_data;
                    tx_period_n = bit_period;
                    tx_n        = 1'b0;
                    tx_busy_n   = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == tx_last) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                    tx_idx_n   = '0;
                    tx_n       = tx_sh_q[0];
                    tx_sh_n    = tx_sh_q >> 1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == tx_last) begin
                    tx_cnt_n = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_n       = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx_q + 3'd1;
                        tx_n     = tx_sh_q[0];
                        tx_sh_n  = tx_sh_q >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == tx_last) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                    tx_busy_n  = 1'b0;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    uart_rx #(
        .CFG_W (CFG_W)
    ) u_rx (
        .clk        (clk),
        .rstb       (rstb),
        .bit_period (bit_period),
        .rx         (rx),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data)
    );

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: reset values, tx bit pattern, ignored requests, period clamp,
// rx glitch / framing error, reset mid-frame, and a 200-byte loopback run.
module tb_uart;
    import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] baudrate_cfg;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx;
    logic        rx_line;
    logic        loop_en;
    logic        rx_drv;

    int n_cmp = 0;
    int n_err = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    uart #(.CFG_W(16)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .baudrate_cfg (baudrate_cfg),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_busy      (tx_busy),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx           (tx),
        .rx           (rx_line)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a transmit at the current negedge and follow it for 10*b cycles.
    // Cycle j is the negedge after edge k+j, k being the accepting edge.
    task automatic tx_frame(input logic [7:0] d, input int b, input bit inject, input bit check_rx);
        int nv, vcyc, bfall;
        logic [7:0] vd;
        nv = 0; vcyc = -1; bfall = -1; vd = 8'h00;
        wr_en = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        wr_data = 8'($urandom_range(0, 255));
        for (int j = 0; j <= 10 * b; j++) begin
            if (rx_valid) begin
                nv++;
                vcyc = j;
                vd = rx_data;
            end
            if (!tx_busy && bfall < 0) bfall = j;
            if (inject && j == 50) begin
                wr_en = 1'b1;
                wr_data = 8'h3C;
            end
            if (inject && j == 51) wr_en = 1'b0;
            if (j < 10 * b) @(negedge clk);
        end
        chk("busy_fall", bfall, 10 * b);
        if (check_rx) begin
            chk("rx_count", nv, 1);
            chk("rx_latency", vcyc, 9 * b + b / 2 + SYNC_LAT);
            chk("rx_byte", {24'h0, vd}, {24'h0, d});
        end
    endtask

    // Drive one frame on rx from the bench, then idle 2*b cycles, counting rx_valid pulses.
    task automatic drive_rx(input logic [7:0] d, input logic stop, input int b,
                            output int nv, output logic [7:0] vd);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        nv = 0;
        vd = 8'h00;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < b; c++) begin
                rx_drv = (i < 10) ? bits[i] : 1'b1;
                @(negedge clk);
                if (rx_valid) begin
                    nv++;
                    vd = rx_data;
                end
            end
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] a5_bits;
        int nv;
        logic [7:0] vd;
        logic [7:0] last_rx;
        logic [7:0] rnd;

        // reset
        rstb = 1'b0;
        baudrate_cfg = 16'd18;
        wr_en = 1'b0;
        wr_data = 8'h00;
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 waveform: start, 1,0,1,0,0,1,0,1, stop; 18 cycles per bit
        a5_bits = 10'b1101001010;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        wr_data = 8'h00;
        for (int j = 0; j < 180; j++) begin
            chk("a5_tx_bit", tx, a5_bits[j / 18]);
            chk("a5_busy_high", tx_busy, 1);
            @(negedge clk);
        end
        chk("a5_busy_low", tx_busy, 0);
        chk("a5_tx_idle", tx, 1);

        // 0x00 in loopback with a 0x3C request mid-frame that must be ignored
        loop_en = 1'b1;
        tx_frame(8'h00, 18, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("ignored_busy", tx_busy, 0);
        chk("ignored_tx", tx, 1);
        chk("ignored_rx_data", rx_data, 8'h00);

        // period below the minimum runs as 4; odd period 5
        baudrate_cfg = 16'd2;
        tx_frame(8'h5A, 4, 1'b0, 1'b1);
        baudrate_cfg = 16'd5;
        tx_frame(8'hC3, 5, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        baudrate_cfg = 16'd18;
        last_rx = 8'hC3;

        // short low glitch on rx
        loop_en = 1'b0;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        nv = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rx_valid) nv++;
        end
        chk("glitch_no_valid", nv, 0);
        chk("glitch_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        chk("glitch_rx_data", rx_data, last_rx);

        // framing error: stop bit low
        drive_rx(8'h81, 1'b0, 18, nv, vd);
        chk("frame_err_no_valid", nv, 0);
        chk("frame_err_rx_data", rx_data, last_rx);
        chk("frame_err_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));

        // good externally driven frame after the error
        drive_rx(8'h96, 1'b1, 18, nv, vd);
        chk("ext_count", nv, 1);
        chk("ext_byte", vd, 8'h96);
        chk("ext_rx_data", rx_data, 8'h96);

        // reset during the data bits of 0x00
        loop_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h00;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (54) @(negedge clk);
        chk("pre_rst_tx_low", tx, 0);
        chk("pre_rst_busy", tx_busy, 1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        nv = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rx_valid) nv++;
        end
        chk("post_rst_no_valid", nv, 0);
        chk("post_rst_rx_data", rx_data, 0);
        tx_frame(8'hE7, 18, 1'b0, 1'b1);

        // 200 random bytes back to back in loopback
        for (int n = 0; n < 200; n++) begin
            rnd = 8'($urandom_range(0, 255));
            tx_frame(rnd, 18, 1'b0, 1'b1);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
